// File: rtl/ysyx_25040105_pkg.sv
// Shared types and constants for the two-master memory arbiter.
//   arb_state_t     : arbiter FSM states
//   GNT_IFU/GNT_LSU : grant encoding carried on gnt_lsu
//   DEFAULT_TIMEOUT : default watchdog budget in cycles
package ysyx_25040105_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/ysyx_25040105_wdog_cnt.sv
// Clearable watchdog up-counter with terminal-count flag.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart count at zero (wins over en)
//   en       : count this cycle
//   tc       : count has reached TIMEOUT-1
module ysyx_25040105_wdog_cnt
  import ysyx_25040105_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_25040105_mem_arbiter.sv
// Fixed-priority (LSU over IFU) arbiter onto one memory port, one
// transaction outstanding, with a watchdog that converts a hung memory
// into an error response.
//   ifu_req_* / ifu_resp_* : instruction-fetch master (read only)
//   lsu_req_* / lsu_resp_* : load/store master
//   mem_req_* / mem_resp_* : shared downstream memory port
//   busy                   : arbiter is not idle
//   gnt_lsu                : current/last grant is the LSU
module ysyx_25040105_mem_arbiter
  import ysyx_25040105_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_req_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_W-1:0]     ifu_resp_rdata,
  output logic                  ifu_resp_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_req_addr,
  input  logic                  lsu_req_wen,
  input  logic [DATA_W-1:0]     lsu_req_wdata,
  input  logic [DATA_W/8-1:0]   lsu_req_wmask,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_W-1:0]     lsu_resp_rdata,
  output logic                  lsu_resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wmask,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_W-1:0]     mem_resp_rdata,
  input  logic                  mem_resp_err,
  output logic                  busy,
  output logic                  gnt_lsu
);

  arb_state_t           state;
  logic [ADDR_W-1:0]    req_addr;
  logic                 req_wen;
  logic [DATA_W-1:0]    req_wdata;
  logic [DATA_W/8-1:0]  req_wmask;
  logic [DATA_W-1:0]    rsp_rdata;
  logic                 rsp_err;
  logic                 stale;

  logic ifu_hs;
  logic lsu_hs;
  logic resp_hs;
  logic wd_tc;

  // Readies are forced low while reset is asserted.
  assign lsu_req_ready = (state == ST_IDLE) && !rst;
  assign ifu_req_ready = (state == ST_IDLE) && !rst && !lsu_req_valid;

  assign ifu_hs  = ifu_req_valid && ifu_req_ready;
  assign lsu_hs  = lsu_req_valid && lsu_req_ready;
  assign resp_hs = (gnt_lsu == GNT_LSU) ? lsu_resp_ready : ifu_resp_ready;

  assign mem_req_valid  = (state == ST_ISSUE);
  assign mem_resp_ready = (state == ST_WAIT);
  assign busy           = (state != ST_IDLE);

  assign mem_req_addr  = req_addr;
  assign mem_req_wen   = req_wen;
  assign mem_req_wdata = req_wdata;
  assign mem_req_wmask = req_wmask;

  assign ifu_resp_valid = (state == ST_RESP) && (gnt_lsu == GNT_IFU);
  assign lsu_resp_valid = (state == ST_RESP) && (gnt_lsu == GNT_LSU);
  assign ifu_resp_rdata = rsp_rdata;
  assign lsu_resp_rdata = rsp_rdata;
  assign ifu_resp_err   = rsp_err;
  assign lsu_resp_err   = rsp_err;

  // Watchdog restarts on every accept and runs through ISSUE and WAIT.
  ysyx_25040105_wdog_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr ((state == ST_IDLE) && (ifu_hs || lsu_hs)),
    .en  ((state == ST_ISSUE) || (state == ST_WAIT)),
    .tc  (wd_tc)
  );

  // Arbiter FSM with registered request/response payloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt_lsu   <= GNT_IFU;
      req_addr  <= '0;
      req_wen   <= 1'b0;
      req_wdata <= '0;
      req_wmask <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      stale     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lsu_hs) begin
            gnt_lsu   <= GNT_LSU;
            req_addr  <= lsu_req_addr;
            req_wen   <= lsu_req_wen;
            req_wdata <= lsu_req_wdata;
            req_wmask <= lsu_req_wmask;
            state     <= ST_ISSUE;
          end else if (ifu_hs) begin
            gnt_lsu   <= GNT_IFU;
            req_addr  <= ifu_req_addr;
            req_wen   <= 1'b0;
            req_wdata <= '0;
            req_wmask <= '0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Timing out here never reached memory, so no late response.
          if (mem_req_ready) begin
            state <= ST_WAIT;
          end else if (wd_tc) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          // A response while stale belongs to an abandoned transaction.
          if (mem_resp_valid && !stale) begin
            rsp_rdata <= mem_resp_rdata;
            rsp_err   <= mem_resp_err;
            state     <= ST_RESP;
          end else if (wd_tc) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            stale     <= 1'b1;
            state     <= ST_RESP;
          end else if (mem_resp_valid) begin
            stale <= 1'b0;
          end
        end
        ST_RESP: begin
          if (resp_hs) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_mem_arbiter.sv
// Self-checking bench for ysyx_25040105_mem_arbiter (TIMEOUT=8).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_ysyx_25040105_mem_arbiter;
  import ysyx_25040105_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic clk, rst;
  logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [AW-1:0] ifu_req_addr;
  logic [DW-1:0] ifu_resp_rdata;
  logic lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_resp_rdata;
  logic [DW/8-1:0] lsu_req_wmask;
  logic mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_resp_rdata;
  logic [DW/8-1:0] mem_req_wmask;
  logic busy, gnt_lsu;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          lsu;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_25040105_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
    .busy(busy), .gnt_lsu(gnt_lsu)
  );

  // Scoreboard: each new master response is matched against the oldest expectation.
  logic          in_resp;
  exp_t          mon_e;
  logic [DW-1:0] mon_rdata;
  logic          mon_err;
  always @(negedge clk) begin
    if (rst) begin
      in_resp = 1'b0;
    end else if (ifu_resp_valid || lsu_resp_valid) begin
      if (!in_resp) begin
        in_resp = 1'b1;
        checks++;
        mon_rdata = lsu_resp_valid ? lsu_resp_rdata : ifu_resp_rdata;
        mon_err   = lsu_resp_valid ? lsu_resp_err : ifu_resp_err;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: ifu_v=%0b lsu_v=%0b rdata=%h, required no response",
                   ifu_resp_valid, lsu_resp_valid, mon_rdata);
        end else begin
          mon_e = sb.pop_front();
          if ((ifu_resp_valid && lsu_resp_valid) || lsu_resp_valid !== mon_e.lsu ||
              mon_rdata !== mon_e.rdata || mon_err !== mon_e.err) begin
            errors++;
            $display("FAIL resp_data: ifu_v=%0b lsu_v=%0b rdata=%h err=%0b, required lsu=%0b rdata=%h err=%0b",
                     ifu_resp_valid, lsu_resp_valid, mon_rdata, mon_err,
                     mon_e.lsu, mon_e.rdata, mon_e.err);
          end
        end
      end
    end else begin
      in_resp = 1'b0;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (dut.state !== ST_IDLE || busy !== 1'b0 || gnt_lsu !== 1'b0 || mem_req_valid !== 1'b0 ||
        mem_resp_ready !== 1'b0 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 ||
        dut.stale !== 1'b0 || mem_req_addr !== '0 || ifu_resp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_state: state=%0d busy=%0b gnt=%0b mreq_v=%0b mresp_r=%0b stale=%0b, required all 0",
               dut.state, busy, gnt_lsu, mem_req_valid, mem_resp_ready, dut.stale);
    end
    checks++;
    if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ifu_rdy=%0b lsu_rdy=%0b, required 0 0", ifu_req_ready, lsu_req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ifu_read();
    @(negedge clk);                                   // cycle 0
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++; $display("FAIL ifu_accept: ready=%0b, required 1", ifu_req_ready);
    end
    @(negedge clk);                                   // cycle 1
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_wen !== 1'b0 ||
        mem_req_wmask !== 4'h0 || gnt_lsu !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ifu_issue: v=%0b addr=%h wen=%0b mask=%h gnt=%0b, required 1 80000000 0 0 0",
               mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, gnt_lsu);
    end
    @(negedge clk);                                   // cycle 2
    mem_req_ready = 1'b0;
    checks++;
    if (mem_resp_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL ifu_wait: resp_ready=%0b req_valid=%0b, required 1 0", mem_resp_ready, mem_req_valid);
    end
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0413; mem_resp_err = 1'b0;
    sb.push_back(exp_t'{1'b0, 32'h0000_0413, 1'b0});
    @(negedge clk);                                   // cycle 3
    mem_resp_valid = 1'b0;
    checks++;
    if (ifu_resp_valid !== 1'b1 || lsu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL ifu_latency: ifu_v=%0b lsu_v=%0b, required 1 0", ifu_resp_valid, lsu_resp_valid);
    end
    @(negedge clk);                                   // cycle 4
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ifu_done: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
    #1;
    checks++;
    if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      errors++; $display("FAIL prio_ready: lsu_rdy=%0b ifu_rdy=%0b, required 1 0", lsu_req_ready, ifu_req_ready);
    end
    @(negedge clk);
    lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_1000 || mem_req_wen !== 1'b1 ||
        mem_req_wdata !== 32'hDEAD_BEEF || mem_req_wmask !== 4'hF || gnt_lsu !== 1'b1) begin
      errors++;
      $display("FAIL prio_lsu_issue: addr=%h wen=%0b wdata=%h mask=%h gnt=%0b, required 80001000 1 deadbeef f 1",
               mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, gnt_lsu);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0; mem_resp_err = 1'b0;
    sb.push_back(exp_t'{1'b1, 32'h0, 1'b0});
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0 || ifu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_lsu_resp: lsu_v=%0b ifu_v=%0b ifu_rdy=%0b, required 1 0 0",
               lsu_resp_valid, ifu_resp_valid, ifu_req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++; $display("FAIL prio_ifu_next: ifu_rdy=%0b, required 1", ifu_req_ready);
    end
    @(negedge clk);
    ifu_req_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004 || gnt_lsu !== 1'b0 || mem_req_wen !== 1'b0) begin
      errors++;
      $display("FAIL prio_ifu_issue: v=%0b addr=%h gnt=%0b wen=%0b, required 1 80000004 0 0",
               mem_req_valid, mem_req_addr, gnt_lsu, mem_req_wen);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1122_3344; mem_resp_err = 1'b0;
    sb.push_back(exp_t'{1'b0, 32'h1122_3344, 1'b0});
    @(negedge clk);
    mem_resp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_req_stall();
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'h0BAD_F00D; lsu_req_wmask = 4'h3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_2000 || mem_req_wen !== 1'b1 ||
          mem_req_wdata !== 32'h0BAD_F00D || mem_req_wmask !== 4'h3) begin
        errors++;
        $display("FAIL stall_stable c%0d: v=%0b addr=%h wen=%0b wdata=%h mask=%h, required 1 80002000 1 0badf00d 3",
                 c, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
      end
      if (c == 4) mem_req_ready = 1'b1;
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_00AA; mem_resp_err = 1'b1;
    sb.push_back(exp_t'{1'b1, 32'h0000_00AA, 1'b1});
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    checks++;
    if (lsu_resp_valid !== 1'b1 || lsu_resp_err !== 1'b1) begin
      errors++; $display("FAIL stall_err: lsu_v=%0b err=%0b, required 1 1", lsu_resp_valid, lsu_resp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    @(negedge clk);                                   // cycle 0
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0100;
    @(negedge clk);                                   // cycle 1: enter ISSUE
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      if (c == 2) begin
        mem_req_ready = 1'b0;
        sb.push_back(exp_t'{1'b0, 32'h0, 1'b1});
      end
      checks++;
      if (ifu_resp_valid !== (c == 9)) begin
        errors++; $display("FAIL timeout_cycle c%0d: ifu_v=%0b, required %0b", c, ifu_resp_valid, (c == 9));
      end
    end
    checks++;
    if (dut.stale !== 1'b1) begin
      errors++; $display("FAIL timeout_stale: stale=%0b, required 1", dut.stale);
    end
    @(negedge clk);                                   // cycle 10
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0104;
    @(negedge clk);                                   // cycle 11
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);                                   // cycle 12: late response
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_DEAD; mem_resp_err = 1'b0;
    @(negedge clk);                                   // cycle 13
    checks++;
    if (busy !== 1'b1 || ifu_resp_valid !== 1'b0 || dut.stale !== 1'b0 || mem_resp_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_discard: busy=%0b ifu_v=%0b stale=%0b mresp_r=%0b, required 1 0 0 1",
               busy, ifu_resp_valid, dut.stale, mem_resp_ready);
    end
    mem_resp_rdata = 32'h5555_AAAA;
    sb.push_back(exp_t'{1'b0, 32'h5555_AAAA, 1'b0});
    @(negedge clk);                                   // cycle 14
    mem_resp_valid = 1'b0;
    checks++;
    if (ifu_resp_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_second: ifu_v=%0b, required 1", ifu_resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_resp_stall();
    @(negedge clk);
    lsu_resp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1'b0;
    @(negedge clk);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678; mem_resp_err = 1'b0;
    sb.push_back(exp_t'{1'b1, 32'h1234_5678, 1'b0});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      checks++;
      if (lsu_resp_valid !== 1'b1 || lsu_resp_rdata !== 32'h1234_5678 || lsu_req_ready !== 1'b0 ||
          ifu_req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL resp_hold c%0d: v=%0b rdata=%h lsu_rdy=%0b ifu_rdy=%0b busy=%0b, required 1 12345678 0 0 1",
                 c, lsu_resp_valid, lsu_resp_rdata, lsu_req_ready, ifu_req_ready, busy);
      end
    end
    @(negedge clk);
    lsu_resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || lsu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL resp_release: busy=%0b lsu_v=%0b, required 0 0", busy, lsu_resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    // First leave a stale response pending via a WAIT timeout.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0300;
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    sb.push_back(exp_t'{1'b0, 32'h0, 1'b1});
    for (int c = 3; c <= 9; c++) @(negedge clk);
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0304;
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);                                   // in WAIT
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0308;
    #1;
    checks++;
    if (dut.state !== ST_IDLE || busy !== 1'b0 || mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0 ||
        lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b0 || dut.stale !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: state=%0d busy=%0b mreq_v=%0b stale=%0b, required 0 0 0 0",
               dut.state, busy, mem_req_valid, dut.stale);
    end
    checks++;
    if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_ready: ifu_rdy=%0b lsu_rdy=%0b, required 0 0", ifu_req_ready, lsu_req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_accept: ifu_rdy=%0b, required 1", ifu_req_ready);
    end
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0308) begin
      errors++; $display("FAIL midrst_issue: v=%0b addr=%h, required 1 80000308", mem_req_valid, mem_req_addr);
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D; mem_resp_err = 1'b0;
    sb.push_back(exp_t'{1'b0, 32'hCAFE_F00D, 1'b0});
    @(negedge clk);
    mem_resp_valid = 1'b0;
    checks++;
    if (ifu_resp_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_resp: ifu_v=%0b, required 1", ifu_resp_valid);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_resp_ready = 1'b1;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_resp_ready = 1'b1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;

    test_reset();
    test_ifu_read();
    test_priority();
    test_req_stall();
    test_timeout();
    test_resp_stall();
    test_reset_mid();

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
